// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small TX FIFO; each frame runs with the
// format and baud divisor that were in effect when its byte left the FIFO.
module uart_tx_cfg #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [7:0]                    byte_in,
  output logic                          tx_serial,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_push;
  logic             w_tick;
  logic             w_last_data;
  logic             w_last_stop;
  logic [7:0]       w_head;
  logic [7:0]       w_mask;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_bits;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop2;
  logic [7:0]       r_data;
  logic [2:0]       r_bit_idx;
  logic             r_tx;

  assign wr_ready    = (r_level != LW'(FIFO_DEPTH));
  assign w_push      = wr_valid && wr_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_tick      = (r_cnt == '0);
  assign w_last_data = (r_bit_idx == (3'(r_bits) + 3'd4));
  assign w_last_stop = (r_bit_idx[0] == r_stop2);
  assign busy        = (r_state != IDLE) || (r_level != '0);
  assign fifo_level  = r_level;
  assign tx_serial   = r_tx;

  // Data-length mask: bits above the frame length never reach the line or the parity.
  always_comb begin
    w_mask = 8'hFF;
    case (cfg_data_bits)
      2'd0:    w_mask = 8'h1F;
      2'd1:    w_mask = 8'h3F;
      2'd2:    w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state; w_load pops the FIFO head and latches the frame configuration.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_next = START;
          w_load = 1'b1;
        end
      end
      START:  if (w_tick) w_next = DATA;
      DATA:   if (w_tick && w_last_data) w_next = r_par_en ? PARITY : STOP;
      PARITY: if (w_tick) w_next = STOP;
      STOP: begin
        if (w_tick && w_last_stop) begin
          if (r_level != '0) begin
            w_next = START;
            w_load = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_load);
    end
  end

  // Frame registers, bit-period down-counter and bit index (restarts on every state change).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
      r_data    <= '0;
      r_bit_idx <= '0;
    end else if (w_load) begin
      r_div     <= cfg_div;
      r_cnt     <= cfg_div;
      r_bits    <= cfg_data_bits;
      r_par_en  <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
      r_par_bit <= (^(w_head & w_mask)) ^ (cfg_parity == 2'd2);
      r_stop2   <= cfg_stop2;
      r_data    <= w_head & w_mask;
      r_bit_idx <= '0;
    end else if (r_state != IDLE) begin
      if (w_tick) begin
        r_cnt     <= r_div;
        r_bit_idx <= (w_next != r_state) ? 3'd0 : r_bit_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx <= 1'b1;
    end else begin
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_data[r_bit_idx];
        PARITY:  r_tx <= r_par_bit;
        default: r_tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: frames expected at push time are queued, a line monitor
// collects per-clock samples of each frame, and each test compares the two.
module tb_uart_tx_cfg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div = 16'd3;
  logic [1:0]  cfg_data_bits = 2'd3;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  byte_in = 8'h00;
  logic        tx_serial;
  logic        busy;
  logic [2:0]  fifo_level;

  typedef struct {
    logic [127:0] smp;
    int           len;
  } exp_t;

  typedef struct {
    logic [127:0] smp;
    int           len;
    int           t0;
    int           t1;
  } rx_t;

  exp_t exp_q[$];
  rx_t  rx_q[$];
  int   len_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int spur = 0;

  uart_tx_cfg #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .byte_in(byte_in), .tx_serial(tx_serial),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-clock line samples of one frame, LSB-first in time.
  function automatic exp_t make_frame(input logic [7:0] b, input logic [1:0] db,
                                      input logic [1:0] par, input logic s2,
                                      input logic [15:0] div);
    logic [15:0] line;
    int          nb;
    int          n;
    int          k;
    logic        p;
    exp_t        e;
    line = '0;
    nb   = 0;
    p    = 1'b0;
    n    = int'(db) + 5;
    line[nb] = 1'b0; nb++;
    for (int i = 0; i < n; i++) begin
      line[nb] = b[i];
      p = p ^ b[i];
      nb++;
    end
    if (par == 2'd1 || par == 2'd2) begin
      line[nb] = (par == 2'd2) ? ~p : p;
      nb++;
    end
    line[nb] = 1'b1; nb++;
    if (s2) begin
      line[nb] = 1'b1; nb++;
    end
    e.smp = '0;
    e.len = nb * (int'(div) + 1);
    k = 0;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j <= int'(div); j++) begin
        e.smp[k] = line[i];
        k++;
      end
    end
    return e;
  endfunction

  // Line monitor: samples 2 time units after each edge, frames start on a low line.
  logic         m_in = 1'b0;
  int           m_idx;
  int           m_len;
  int           m_t0;
  logic [127:0] m_smp;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      m_in = 1'b0;
      len_q.delete();
    end else begin
      if (!m_in && tx_serial === 1'b0) begin
        if (len_q.size() > 0) begin
          m_in  = 1'b1;
          m_len = len_q.pop_front();
          m_idx = 0;
          m_smp = '0;
          m_t0  = cyc;
        end else begin
          spur++;
        end
      end
      if (m_in) begin
        m_smp[m_idx] = tx_serial;
        m_idx++;
        if (m_idx == m_len) begin
          rx_q.push_back('{m_smp, m_len, m_t0, cyc});
          m_in = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offers b starting at the current negedge and returns at the negedge after acceptance.
  task automatic push(input logic [7:0] b);
    int   t;
    exp_t e;
    byte_in  = b;
    wr_valid = 1'b1;
    t = 0;
    while (!wr_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!wr_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: wr_ready stayed %b for byte %h", wr_ready, b);
      wr_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      e = make_frame(b, cfg_data_bits, cfg_parity, cfg_stop2, cfg_div);
      exp_q.push_back(e);
      len_q.push_back(e.len);
    end
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL frame_count: got %0d frames, need %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    wr_valid = 1'b1;
    byte_in  = 8'hFF;
    tick(3);
    checks += 4;
    if (tx_serial !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b need 1", tx_serial); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d need 0", fifo_level); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b need 1", wr_ready); end
    rst      = 1'b0;
    wr_valid = 1'b0;
    tick(2);
    checks++;
    if (fifo_level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle: level %0d busy %b, need 0 0", fifo_level, busy);
    end
  endtask

  task automatic test_8n1();
    rx_t  r;
    exp_t e;
    int   a;
    cfg_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    push(8'hA5);
    wr_valid = 1'b0;
    a = acc_cyc;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL 8n1_busy: got %b need 1", busy); end
    wait_frames(1);
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks += 2;
      if (r.smp !== e.smp) begin errors++; $display("FAIL 8n1_frame: got %h need %h", r.smp, e.smp); end
      if (r.t0 - a != 2) begin errors++; $display("FAIL 8n1_latency: got %0d edges need 2", r.t0 - a); end
    end
    tick(2);
    checks++;
    if (busy !== 1'b0 || tx_serial !== 1'b1) begin
      errors++;
      $display("FAIL 8n1_idle: busy %b tx %b, need 0 1", busy, tx_serial);
    end
  endtask

  task automatic test_7e2();
    rx_t          r;
    exp_t         e;
    logic [127:0] lit;
    cfg_div = 16'd0; cfg_data_bits = 2'd2; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
    lit = 128'h606;
    push(8'h83);
    wr_valid = 1'b0;
    wait_frames(1);
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks += 2;
      if (r.smp !== e.smp) begin errors++; $display("FAIL 7e2_frame: got %h need %h", r.smp, e.smp); end
      if (r.smp !== lit) begin errors++; $display("FAIL 7e2_literal: got %h need %h", r.smp, lit); end
    end
    tick(3);
  endtask

  task automatic test_5o1();
    rx_t          r;
    exp_t         e;
    logic [127:0] lit;
    cfg_div = 16'd0; cfg_data_bits = 2'd0; cfg_parity = 2'd2; cfg_stop2 = 1'b0;
    lit = 128'hBE;
    push(8'h1F);
    wr_valid = 1'b0;
    wait_frames(1);
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks += 2;
      if (r.smp !== e.smp) begin errors++; $display("FAIL 5o1_frame: got %h need %h", r.smp, e.smp); end
      if (r.smp !== lit) begin errors++; $display("FAIL 5o1_literal: got %h need %h", r.smp, lit); end
    end
    tick(3);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    rx_t        r [6];
    exp_t       e;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cfg_div = 16'd1; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    for (int i = 0; i < 5; i++) push(bytes[i]);
    checks += 2;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b need 0", wr_ready); end
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_full_level: got %0d need 4", fifo_level); end
    push(bytes[5]);
    wr_valid = 1'b0;
    wait_frames(6);
    if (rx_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        r[i] = rx_q.pop_front();
        e    = exp_q.pop_front();
        checks++;
        if (r[i].smp !== e.smp) begin
          errors++;
          $display("FAIL b2b_frame%0d: got %h need %h", i, r[i].smp, e.smp);
        end
        if (i > 0) begin
          checks++;
          if (r[i].t0 != r[i-1].t1 + 1) begin
            errors++;
            $display("FAIL b2b_gap%0d: start %0d, need %0d", i, r[i].t0, r[i-1].t1 + 1);
          end
        end
      end
    end
    tick(3);
  endtask

  task automatic test_cfg_change();
    rx_t  r;
    exp_t e;
    cfg_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    push(8'h3C);
    wr_valid = 1'b0;
    tick(10);
    cfg_div = 16'd7;
    push(8'hC3);
    wr_valid = 1'b0;
    wait_frames(2);
    for (int i = 0; i < 2; i++) begin
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (r.smp !== e.smp) begin
          errors++;
          $display("FAIL cfgchg_frame%0d: got %h need %h", i, r.smp, e.smp);
        end
      end
    end
    tick(3);
  endtask

  task automatic test_reset_midframe();
    int lows;
    cfg_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    wr_valid = 1'b0;
    tick(10);
    checks++;
    if (fifo_level !== 3'd2) begin errors++; $display("FAIL midrst_pre_level: got %0d need 2", fifo_level); end
    rst      = 1'b1;
    wr_valid = 1'b1;
    byte_in  = 8'h77;
    tick(1);
    rst      = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    rx_q.delete();
    checks += 4;
    if (tx_serial !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b need 1", tx_serial); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d need 0", fifo_level); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b need 0", busy); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b need 1", wr_ready); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) lows++;
    end
    checks += 2;
    if (lows != 0) begin errors++; $display("FAIL midrst_quiet: got %0d low samples need 0", lows); end
    if (rx_q.size() != 0) begin errors++; $display("FAIL midrst_frames: got %0d frames need 0", rx_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_back_to_back();
    test_cfg_change();
    test_reset_midframe();
    checks++;
    if (spur != 0) begin errors++; $display("FAIL spurious_start: got %0d unexpected low samples need 0", spur); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
